btn_conditioner: RTL

Input-conditioning stage directly upstream of the ALU operand-entry block. Synchronizes the raw board push-buttons and slide switches into `clk`, debounces each button, and emits a clean one-cycle press strobe. The operand-entry logic then shifts nibbles on a single-cycle enable instead of clocking on raw, bouncing button edges.

---
 rtl/btn_cond_pkg.sv | 15 +
 rtl/debounce_ch.sv | 149 ++++++++++++++
 rtl/btn_conditioner.sv | 51 +++++
 3 files changed

// File: rtl/btn_cond_pkg.sv
// Shared types and default timing constants for the button conditioner.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } btn_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY    = 50000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-FF sync, saturating stable counter, debounce FSM, registered level/strobe.
// Press/release accepted DEBOUNCE_CYCLES+1 clocks after first raw sample; BTN_AUTOREPEAT_EN adds repeat strobes.
module debounce_ch
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("debounce_ch: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
    end

    logic [1:0]       sync_q;
    logic             in_s;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic             rep_fire;

    assign in_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!in_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!in_s) begin
                    state_d = REL_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            REL_WAIT: begin
                // A return to 1 here is release bounce, not a new press.
                if (in_s) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX) + 1;

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_arm_q, rep_arm_d;
    logic [REP_W-1:0] rep_limit;

    // Before the first repeat, wait REPEAT_DELAY; afterwards REPEAT_PERIOD.
    assign rep_limit = rep_arm_q ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);

    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_arm_d = rep_arm_q;
        rep_fire  = 1'b0;
        if (pulse_d) begin
            rep_cnt_d = '0;
            rep_arm_d = 1'b0;
        end else if (state_q == HELD && in_s) begin
            if (rep_cnt_q == rep_limit) begin
                rep_fire  = 1'b1;
                rep_cnt_d = '0;
                rep_arm_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end else if (state_d == IDLE) begin
            rep_cnt_d = '0;
            rep_arm_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rep_cnt_q <= '0;
            rep_arm_q <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_arm_q <= rep_arm_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d | rep_fire;
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/btn_conditioner.sv
// Board input conditioner: per-button debounce with one-cycle press strobe, 2-FF synced switches (2 clk).
// Button accept latency DEBOUNCE_CYCLES+1 after first raw sample; optional auto-repeat via BTN_AUTOREPEAT_EN.
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int SW_W            = 16,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn,
    input  logic [SW_W-1:0]  SW,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [SW_W-1:0]  sw_sync
);

    logic [SW_W-1:0] sw_meta_q;
    logic [SW_W-1:0] sw_sync_q;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .btn_i  (btn[g]),
            .level_o(btn_level[g]),
            .pulse_o(btn_pulse[g])
        );
    end

    // Switches are levels read by software-paced logic; sync only, no debounce.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= SW;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign sw_sync = sw_sync_q;

endmodule
